// File: rtl/rpn_evaluator.sv
// rpn_evaluator: RPN token stream evaluator driving an external stack, result/error on a valid/ready port.
module rpn_evaluator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [1:0]       tok_type,
    input  logic [1:0]       tok_op,
    input  logic [WIDTH-1:0] tok_data,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_wdata,
    input  logic [WIDTH-1:0] stk_rdata,
    input  logic             stk_full,
    input  logic             stk_empty,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [1:0]       res_err
);
    typedef enum logic [3:0] {IDLE, POPB, POPA, PUSH, FIN, CHK, FLUSH, DRAIN, RESULT} state_e;
    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d, err_q, err_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, alu;
    logic             end_q, end_d;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            op_q    <= '0;
            err_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            end_q   <= end_d;
        end
    end
    always_comb
        alu = op_q == 2'b00 ? a_q + b_q : op_q == 2'b01 ? a_q - b_q : op_q == 2'b10 ? a_q * b_q : a_q & b_q;
    // end_q marks an error raised after END was consumed, so DRAIN must not wait for another END
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        err_d     = err_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        end_d     = end_q;
        tok_ready = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_wdata = '0;
        case (state_q)
            IDLE: begin
                tok_ready = 1'b1;
                if (tok_valid)
                    case (tok_type)
                        2'b00: if (!stk_full) begin
                            stk_push  = 1'b1;
                            stk_wdata = tok_data;
                        end else begin
                            err_d   = 2'b10;
                            state_d = FLUSH;
                        end
                        2'b01: begin
                            op_d    = tok_op;
                            state_d = POPB;
                        end
                        2'b10: state_d = FIN;
                        default: begin
                            err_d   = 2'b11;
                            state_d = FLUSH;
                        end
                    endcase
            end
            POPB: if (stk_empty) begin
                err_d   = 2'b01;
                state_d = FLUSH;
            end else begin
                stk_pop = 1'b1;
                b_d     = stk_rdata;
                state_d = POPA;
            end
            POPA: if (stk_empty) begin
                err_d   = 2'b01;
                state_d = FLUSH;
            end else begin
                stk_pop = 1'b1;
                a_d     = stk_rdata;
                state_d = PUSH;
            end
            PUSH: begin
                stk_push  = 1'b1;
                stk_wdata = alu;
                state_d   = IDLE;
            end
            FIN: begin
                end_d = 1'b1;
                if (stk_empty) begin
                    err_d   = 2'b01;
                    state_d = DRAIN;
                end else begin
                    stk_pop = 1'b1;
                    res_d   = stk_rdata;
                    state_d = CHK;
                end
            end
            CHK: if (stk_empty) state_d = RESULT;
            else begin
                err_d   = 2'b11;
                res_d   = '0;
                state_d = FLUSH;
            end
            FLUSH: if (stk_empty) state_d = DRAIN;
            else stk_pop = 1'b1;
            DRAIN: begin
                tok_ready = !end_q;
                if (end_q || (tok_valid && tok_type == 2'b10)) state_d = RESULT;
            end
            RESULT: if (res_ready) begin
                err_d   = '0;
                res_d   = '0;
                end_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign res_valid = state_q == RESULT;
    assign res_data  = res_q;
    assign res_err   = err_q;
endmodule
